// File: rtl/fduart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing the UART TX FIFO write port among NUM_REQ byte streams.
// Optional mid-message stall release is enabled by defining FDUART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick the next valid requester starting at the rr pointer
// SEND  | grant held by arb_grant_id until its req_last byte is accepted (or stall timeout)
module fduart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   sysclk,
    input  logic                   sysreset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   atx_fifo_full,
    output logic [15:0]            atx_data,
    output logic                   atx_reg_load,
    output logic                   arb_busy,
    output logic [2:0]             arb_grant_id,
    output logic                   arb_timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("fduart_tx_arbiter: parameter out of range");
    end

    logic [0:0] state;
    logic [2:0] rr_ptr;
    logic       cooldown;

    logic       any_valid;
    logic [2:0] winner;
    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_byte;
    logic       can_send;
    logic       xfer;
    logic [2:0] next_ptr;

    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
        any_valid = found;
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_byte  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_id == 3'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_byte  = req_data[8*i +: 8];
            end
        end
    end

    // cooldown spaces writes two cycles apart so the FIFO full flag has time to update
    assign can_send = (state == SEND) && !atx_fifo_full && !cooldown;
    assign xfer     = can_send && owner_valid;
    assign next_ptr = 3'((int'(arb_grant_id) + 1) % NUM_REQ);
    assign arb_busy = (state == SEND);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = can_send && (arb_grant_id == 3'(i));
        end
    end

`ifdef FDUART_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        timeout_q;
    logic        stall_hit;

    assign stall_hit   = (state == SEND) && !owner_valid && !atx_fifo_full
                         && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign arb_timeout = timeout_q;

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= stall_hit;
            if (state != SEND || xfer || stall_hit) begin
                stall_cnt <= '0;
            end else if (!owner_valid && !atx_fifo_full) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    logic stall_hit;

    assign stall_hit   = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            arb_grant_id <= '0;
            cooldown     <= 1'b0;
            atx_reg_load <= 1'b0;
            atx_data     <= '0;
        end else begin
            cooldown     <= xfer;
            atx_reg_load <= xfer;
            if (xfer) begin
                atx_data <= {8'h00, owner_byte};
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state        <= SEND;
                        arb_grant_id <= winner;
                    end
                end
                SEND: begin
                    if ((xfer && owner_last) || stall_hit) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fduart_tx_arbiter.sv
// Directed bench for fduart_tx_arbiter: cycle table for grant/ordering, hand sequences for FIFO-full and stall.
// Stall release behaviour checked according to whether FDUART_ARB_TIMEOUT_EN is defined.
module tb_fduart_tx_arbiter;

    logic        sysclk = 1'b0;
    logic        sysreset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        atx_fifo_full = 1'b0;
    logic [15:0] atx_data;
    logic        atx_reg_load;
    logic        arb_busy;
    logic [2:0]  arb_grant_id;
    logic        arb_timeout;

    int n_vec = 0;
    int n_bad = 0;

    fduart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .sysclk        (sysclk),
        .sysreset_n    (sysreset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .atx_fifo_full (atx_fifo_full),
        .atx_data      (atx_data),
        .atx_reg_load  (atx_reg_load),
        .arb_busy      (arb_busy),
        .arb_grant_id  (arb_grant_id),
        .arb_timeout   (arb_timeout)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic [3:0]  ready;
        logic        load;
        logic [15:0] adata;
        logic        busy;
        logic [2:0]  gid;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
        @(negedge sysclk);
        req_valid     = v;
        req_last      = l;
        atx_fifo_full = f;
        req_data      = d;
        #1;
    endtask

    initial begin
        int cyc;
        // valid, last, full, data | ready, load, adata, busy, gid
        vt[0]  = '{4'hF, 4'h0, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 16'h0000, 1'b0, 3'd0};
        vt[1]  = '{4'h1, 4'h1, 1'b0, 32'h0000_0010, 4'h1, 1'b0, 16'h0000, 1'b1, 3'd0};
        vt[2]  = '{4'h0, 4'h0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 16'h0010, 1'b0, 3'd0};
        vt[3]  = '{4'h2, 4'h0, 1'b0, 32'h0000_4100, 4'h0, 1'b0, 16'h0010, 1'b0, 3'd0};
        vt[4]  = '{4'h2, 4'h0, 1'b0, 32'h0000_4100, 4'h2, 1'b0, 16'h0010, 1'b1, 3'd1};
        vt[5]  = '{4'h2, 4'h0, 1'b0, 32'h0000_4200, 4'h0, 1'b1, 16'h0041, 1'b1, 3'd1};
        vt[6]  = '{4'h2, 4'h0, 1'b0, 32'h0000_4200, 4'h2, 1'b0, 16'h0041, 1'b1, 3'd1};
        vt[7]  = '{4'h2, 4'h2, 1'b0, 32'h0000_4300, 4'h0, 1'b1, 16'h0042, 1'b1, 3'd1};
        vt[8]  = '{4'h2, 4'h2, 1'b0, 32'h0000_4300, 4'h2, 1'b0, 16'h0042, 1'b1, 3'd1};
        vt[9]  = '{4'h0, 4'h0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 16'h0043, 1'b0, 3'd1};
        vt[10] = '{4'h8, 4'h8, 1'b0, 32'h3300_0000, 4'h0, 1'b0, 16'h0043, 1'b0, 3'd1};
        vt[11] = '{4'h8, 4'h8, 1'b0, 32'h3300_0000, 4'h8, 1'b0, 16'h0043, 1'b1, 3'd3};
        vt[12] = '{4'h5, 4'h0, 1'b0, 32'h00C0_00A0, 4'h0, 1'b1, 16'h0033, 1'b0, 3'd3};
        vt[13] = '{4'h5, 4'h0, 1'b0, 32'h00C0_00A0, 4'h1, 1'b0, 16'h0033, 1'b1, 3'd0};
        vt[14] = '{4'h5, 4'h1, 1'b0, 32'h00C0_00A1, 4'h0, 1'b1, 16'h00A0, 1'b1, 3'd0};
        vt[15] = '{4'h5, 4'h1, 1'b0, 32'h00C0_00A1, 4'h1, 1'b0, 16'h00A0, 1'b1, 3'd0};
        vt[16] = '{4'h4, 4'h0, 1'b0, 32'h00C0_0000, 4'h0, 1'b1, 16'h00A1, 1'b0, 3'd0};
        vt[17] = '{4'h4, 4'h0, 1'b0, 32'h00C0_0000, 4'h4, 1'b0, 16'h00A1, 1'b1, 3'd2};
        vt[18] = '{4'h4, 4'h4, 1'b0, 32'h00C1_0000, 4'h0, 1'b1, 16'h00C0, 1'b1, 3'd2};
        vt[19] = '{4'h4, 4'h4, 1'b0, 32'h00C1_0000, 4'h4, 1'b0, 16'h00C0, 1'b1, 3'd2};
        vt[20] = '{4'h0, 4'h0, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 16'h00C1, 1'b0, 3'd2};
        vt[21] = '{4'h9, 4'h0, 1'b0, 32'hD000_00B0, 4'h0, 1'b0, 16'h00C1, 1'b0, 3'd2};
        vt[22] = '{4'h9, 4'h0, 1'b0, 32'hD000_00B0, 4'h8, 1'b0, 16'h00C1, 1'b1, 3'd3};

        // reset held with every requester valid
        req_valid = 4'hF;
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_ready", -1, 16'(req_ready), 16'h0);
        chk("rst_load", -1, 16'(atx_reg_load), 16'h0);
        chk("rst_data", -1, atx_data, 16'h0);
        chk("rst_busy", -1, 16'(arb_busy), 16'h0);
        chk("rst_gid", -1, 16'(arb_grant_id), 16'h0);
        chk("rst_timeout", -1, 16'(arb_timeout), 16'h0);

        @(negedge sysclk);
        sysreset_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge sysclk);
            req_valid     = vt[i].valid;
            req_last      = vt[i].last;
            atx_fifo_full = vt[i].full;
            req_data      = vt[i].data;
            #1;
            chk("ready", i, 16'(req_ready), 16'(vt[i].ready));
            chk("load", i, 16'(atx_reg_load), 16'(vt[i].load));
            chk("data", i, atx_data, vt[i].adata);
            chk("busy", i, 16'(arb_busy), 16'(vt[i].busy));
            chk("gid", i, 16'(arb_grant_id), 16'(vt[i].gid));
            chk("timeout", i, 16'(arb_timeout), 16'h0);
        end

        // FIFO full for 10 cycles mid-message: owner 3 keeps grant, only the pending D0 strobe appears
        for (int c = 23; c < 33; c++) begin
            drive(4'h9, 4'h0, 1'b1, 32'hD100_00B0);
            chk("full_ready", c, 16'(req_ready), 16'h0);
            chk("full_load", c, 16'(atx_reg_load), (c == 23) ? 16'h1 : 16'h0);
            chk("full_busy", c, 16'(arb_busy), 16'h1);
            chk("full_gid", c, 16'(arb_grant_id), 16'h3);
        end
        drive(4'h9, 4'h0, 1'b0, 32'hD100_00B0);
        chk("unfull_ready", 33, 16'(req_ready), 16'h8);
        drive(4'h9, 4'h8, 1'b0, 32'hD200_00B0);
        chk("unfull_load", 34, 16'(atx_reg_load), 16'h1);
        chk("unfull_data", 34, atx_data, 16'h00D1);
        chk("unfull_ready_cd", 34, 16'(req_ready), 16'h0);
        drive(4'h9, 4'h8, 1'b0, 32'hD200_00B0);
        chk("last_ready", 35, 16'(req_ready), 16'h8);
        drive(4'h3, 4'h0, 1'b0, 32'h0000_00E0);
        chk("rel_load", 36, 16'(atx_reg_load), 16'h1);
        chk("rel_data", 36, atx_data, 16'h00D2);
        chk("rel_busy", 36, 16'(arb_busy), 16'h0);

        // owner 0 sends one byte then stalls with req1 waiting
        drive(4'h3, 4'h0, 1'b0, 32'h0000_00E0);
        chk("stall_gnt_ready", 37, 16'(req_ready), 16'h1);
        chk("stall_gnt_gid", 37, 16'(arb_grant_id), 16'h0);
        cyc = 38;
`ifdef FDUART_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
            chk("to_wait_busy", cyc, 16'(arb_busy), 16'h1);
            chk("to_wait_pulse", cyc, 16'(arb_timeout), 16'h0);
            cyc++;
        end
        drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
        chk("to_pulse", cyc, 16'(arb_timeout), 16'h1);
        chk("to_busy", cyc, 16'(arb_busy), 16'h0);
        chk("to_load", cyc, 16'(atx_reg_load), 16'h0);
        cyc++;
        drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
        chk("to_next_gid", cyc, 16'(arb_grant_id), 16'h1);
        chk("to_next_ready", cyc, 16'(req_ready), 16'h2);
        chk("to_pulse_end", cyc, 16'(arb_timeout), 16'h0);
`else
        for (int k = 0; k < 100; k++) begin
            drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
            chk("hold_busy", cyc, 16'(arb_busy), 16'h1);
            chk("hold_gid", cyc, 16'(arb_grant_id), 16'h0);
            chk("hold_timeout", cyc, 16'(arb_timeout), 16'h0);
            cyc++;
        end
        drive(4'h3, 4'h1, 1'b0, 32'h0000_00E1);
        chk("resume_ready", cyc, 16'(req_ready), 16'h1);
        cyc++;
        drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
        chk("resume_load", cyc, 16'(atx_reg_load), 16'h1);
        chk("resume_data", cyc, atx_data, 16'h00E1);
        chk("resume_busy", cyc, 16'(arb_busy), 16'h0);
        cyc++;
        drive(4'h2, 4'h0, 1'b0, 32'h0000_0000);
        chk("resume_next_gid", cyc, 16'(arb_grant_id), 16'h1);
        chk("resume_next_busy", cyc, 16'(arb_busy), 16'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
